// File: rtl/binoc_pkg.sv
// Shared session states and default timing/width constants for the binocular controller.
// Pure declarations: no latency, no backpressure.
package binoc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    WARN    = 2'd2,
    CLOSING = 2'd3
  } sessState_t;

  localparam int DEF_CLK_HZ         = 10_000_000;
  localparam int DEF_SEC_PER_UNIT   = 6;
  localparam int DEF_CREDIT_W       = 12;
  localparam int DEF_WARN_SEC       = 10;
  localparam int DEF_BLINK_HALF     = 2_500_000;
  localparam int DEF_CLOSE_HOLD_SEC = 2;

  // Shutter is open and credit is being consumed only in these two phases.
  function automatic logic isOpen(input sessState_t s);
    return (s == RUNNING) || (s == WARN);
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running modulo-DIV counter; tick is high for one clock every DIV enabled clocks.
// Tick is a decode of the registered count (zero latency from the count); no backpressure.
module tick_divider #(
  parameter int DIV = 100
) (
  input  logic CLK_10MHZ,
  input  logic nRST,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Tick must not depend on clear: clear is derived from a state change that the tick may cause.
  assign tick = enable && (count == LAST);

  always_ff @(posedge CLK_10MHZ or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/binoc_session_ctrl.sv
// Turns billAccumed increments into seconds of viewing credit and sequences shutter/lamp.
// Input change to creditSec in 2 clocks, to shutterOpen in 3; no backpressure, every increment is credited.
module binoc_session_ctrl
  import binoc_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int SEC_PER_UNIT   = DEF_SEC_PER_UNIT,
  parameter int CREDIT_W       = DEF_CREDIT_W,
  parameter int WARN_SEC       = DEF_WARN_SEC,
  parameter int BLINK_HALF     = DEF_BLINK_HALF,
  parameter int CLOSE_HOLD_SEC = DEF_CLOSE_HOLD_SEC
) (
  input  logic                CLK_10MHZ,
  input  logic                nRST,
  input  logic [7:0]          billAccumed,
  output logic                shutterOpen,
  output logic                warnLamp,
  output logic [CREDIT_W-1:0] creditSec,
  output logic                sessionEnd
);

  localparam int ADD_W  = CREDIT_W + 1;
  localparam int SUM_W  = CREDIT_W + 2;
  localparam int HOLD_W = (CLOSE_HOLD_SEC > 1) ? $clog2(CLOSE_HOLD_SEC) : 1;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
  localparam logic [ADD_W-1:0]    ADD_MAX    = '1;
  localparam logic [CREDIT_W-1:0] WARN_LIM   = CREDIT_W'(WARN_SEC);
  localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(CLOSE_HOLD_SEC - 1);

  sessState_t state, stateNext;

  logic [7:0]          billQ;
  logic [7:0]          lastSeen;
  logic [7:0]          delta;
  logic                primed;
  logic [31:0]         product;
  logic [ADD_W-1:0]    addCalc;
  logic [ADD_W-1:0]    addQ;
  logic [SUM_W-1:0]    creditSum;
  logic [CREDIT_W-1:0] creditNext;
  logic                dec;
  logic                secTick;
  logic                blinkTick;
  logic                phaseChange;
  logic                shutterNext;
  logic                lampNext;
  logic                endNext;
  logic [HOLD_W-1:0]   holdCnt;

  // Delta stage: mod-256 difference makes a wrapped total (250 -> 4) an ordinary credit.
  assign delta   = billQ - lastSeen;
  assign product = 32'(delta) * 32'(SEC_PER_UNIT);
  assign addCalc = (product > 32'(ADD_MAX)) ? ADD_MAX : product[ADD_W-1:0];

  always_ff @(posedge CLK_10MHZ or negedge nRST) begin
    if (!nRST) begin
      billQ    <= '0;
      lastSeen <= '0;
      primed   <= 1'b0;
      addQ     <= '0;
    end else begin
      billQ <= billAccumed;
      if (!primed) begin
        // Adopt whatever total is already present so it is never paid out.
        lastSeen <= billAccumed;
        primed   <= 1'b1;
        addQ     <= '0;
      end else begin
        lastSeen <= billQ;
        addQ     <= addCalc;
      end
    end
  end

  // Single adder for top-up and per-second consumption; dec only when credit > 0, so no underflow.
  assign dec        = secTick && isOpen(state) && (creditSec != '0);
  assign creditSum  = SUM_W'(creditSec) + SUM_W'(addQ) - SUM_W'(dec);
  assign creditNext = (creditSum > SUM_W'(CREDIT_MAX)) ? CREDIT_MAX : creditSum[CREDIT_W-1:0];

  tick_divider #(.DIV(CLK_HZ)) u_secDiv (
    .CLK_10MHZ (CLK_10MHZ),
    .nRST      (nRST),
    .enable    (state != IDLE),
    .clear     (phaseChange),
    .tick      (secTick)
  );

  tick_divider #(.DIV(BLINK_HALF)) u_blinkDiv (
    .CLK_10MHZ (CLK_10MHZ),
    .nRST      (nRST),
    .enable    (state == WARN),
    .clear     (phaseChange),
    .tick      (blinkTick)
  );

  always_comb begin
    stateNext   = state;
    phaseChange = 1'b0;
    shutterNext = 1'b0;
    lampNext    = 1'b0;
    endNext     = 1'b0;

    unique case (state)
      IDLE: begin
        if (creditSec != '0) stateNext = RUNNING;
      end
      RUNNING: begin
        if (creditSec == '0)           stateNext = CLOSING;
        else if (creditSec <= WARN_LIM) stateNext = WARN;
      end
      WARN: begin
        if (creditSec == '0)          stateNext = CLOSING;
        else if (creditSec > WARN_LIM) stateNext = RUNNING;
      end
      CLOSING: begin
        // New money during the hold reopens at once and abandons the hold.
        if (creditSec != '0)                      stateNext = RUNNING;
        else if (secTick && holdCnt == HOLD_LAST) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    phaseChange = (stateNext != state);
    shutterNext = isOpen(stateNext);
    endNext     = phaseChange && (stateNext == CLOSING);
    if (stateNext == WARN) begin
      lampNext = phaseChange ? 1'b1 : (warnLamp ^ blinkTick);
    end
  end

  always_ff @(posedge CLK_10MHZ or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      creditSec   <= '0;
      shutterOpen <= 1'b0;
      warnLamp    <= 1'b0;
      sessionEnd  <= 1'b0;
      holdCnt     <= '0;
    end else begin
      state       <= stateNext;
      creditSec   <= creditNext;
      shutterOpen <= shutterNext;
      warnLamp    <= lampNext;
      sessionEnd  <= endNext;
      if (phaseChange || state != CLOSING) begin
        holdCnt <= '0;
      end else if (secTick) begin
        holdCnt <= holdCnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_binoc_session_ctrl.sv
// Bench for binoc_session_ctrl: directed test-plan scenarios plus random money arrivals,
// every output compared each cycle against a phase/elapsed-time reference model.
module tb_binoc_session_ctrl;

  localparam int CLK_HZ     = 100;
  localparam int SPU        = 6;
  localparam int CW         = 12;
  localparam int WARN_SEC   = 10;
  localparam int BLINK_HALF = 10;
  localparam int HOLD_SEC   = 2;
  localparam int CMAX       = (1 << CW) - 1;

  localparam int PH_OFF  = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_WARN = 2;
  localparam int PH_HOLD = 3;

  logic          CLK_10MHZ = 1'b0;
  logic          nRST;
  logic [7:0]    billAccumed;
  logic          shutterOpen;
  logic          warnLamp;
  logic [CW-1:0] creditSec;
  logic          sessionEnd;

  int nVec  = 0;
  int nMiss = 0;

  binoc_session_ctrl #(
    .CLK_HZ         (CLK_HZ),
    .SEC_PER_UNIT   (SPU),
    .CREDIT_W       (CW),
    .WARN_SEC       (WARN_SEC),
    .BLINK_HALF     (BLINK_HALF),
    .CLOSE_HOLD_SEC (HOLD_SEC)
  ) dut (
    .CLK_10MHZ   (CLK_10MHZ),
    .nRST        (nRST),
    .billAccumed (billAccumed),
    .shutterOpen (shutterOpen),
    .warnLamp    (warnLamp),
    .creditSec   (creditSec),
    .sessionEnd  (sessionEnd)
  );

  always #5 CLK_10MHZ = ~CLK_10MHZ;

  // Reference model: phase plus cycles elapsed in that phase; seconds, blink and hold follow arithmetically.
  int mPrimed, mBillQ, mLast, mAdd, mCredit, mPh, mAge;

  function automatic int secondEnds(input int ph, input int age);
    return (ph != PH_OFF && (age % CLK_HZ) == CLK_HZ - 1) ? 1 : 0;
  endfunction

  function automatic int phaseAfter(input int ph, input int credit, input int age);
    case (ph)
      PH_OFF:  return (credit > 0) ? PH_RUN : PH_OFF;
      PH_RUN:  return (credit == 0) ? PH_HOLD : ((credit <= WARN_SEC) ? PH_WARN : PH_RUN);
      PH_WARN: return (credit == 0) ? PH_HOLD : ((credit > WARN_SEC) ? PH_RUN : PH_WARN);
      default: return (credit > 0) ? PH_RUN : ((age == HOLD_SEC * CLK_HZ - 1) ? PH_OFF : PH_HOLD);
    endcase
  endfunction

  function automatic int creditAfter(input int credit, input int add, input int ph, input int age);
    int c;
    c = credit + add;
    if ((ph == PH_RUN || ph == PH_WARN) && secondEnds(ph, age) == 1 && credit > 0) c = c - 1;
    if (c > CMAX) c = CMAX;
    if (c < 0) c = 0;
    return c;
  endfunction

  always @(posedge CLK_10MHZ or negedge nRST) begin
    if (!nRST) begin
      mPrimed <= 0; mBillQ <= 0; mLast <= 0; mAdd <= 0;
      mCredit <= 0; mPh <= PH_OFF; mAge <= 0;
    end else begin
      mBillQ  <= int'(billAccumed);
      mPrimed <= 1;
      mLast   <= (mPrimed != 0) ? mBillQ : int'(billAccumed);
      mAdd    <= (mPrimed != 0) ? ((mBillQ - mLast + 256) % 256) * SPU : 0;
      mCredit <= creditAfter(mCredit, mAdd, mPh, mAge);
      mPh     <= phaseAfter(mPh, mCredit, mAge);
      mAge    <= (phaseAfter(mPh, mCredit, mAge) != mPh) ? 0 : mAge + 1;
    end
  end

  function automatic int expShut();
    return (mPh == PH_RUN || mPh == PH_WARN) ? 1 : 0;
  endfunction
  function automatic int expLamp();
    return (mPh == PH_WARN) ? (1 ^ ((mAge / BLINK_HALF) % 2)) : 0;
  endfunction
  function automatic int expEnd();
    return (mPh == PH_HOLD && mAge == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    nVec++;
    if (obs != expv) begin
      nMiss++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic stepCycle();
    @(negedge CLK_10MHZ);
    chk("shutterOpen", int'(shutterOpen), expShut());
    chk("warnLamp",    int'(warnLamp),    expLamp());
    chk("sessionEnd",  int'(sessionEnd),  expEnd());
    chk("creditSec",   int'(creditSec),   mCredit);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic bump(input int units);
    billAccumed = billAccumed + 8'(units);
  endtask

  initial begin
    int firstLamp;
    int endCnt;
    int waited;

    // 1: reset with a pre-existing total, nothing is paid out
    nRST = 1'b0;
    billAccumed = 8'd40;
    steps(3);
    nRST = 1'b1;
    steps(20);
    chk("t1_idle_credit", int'(creditSec), 0);
    chk("t1_idle_shutter", int'(shutterOpen), 0);

    // 2: +10 units -> 60 s, full session with warn, end pulse and hold
    bump(10);
    steps(3);
    chk("t2_credit_n2", int'(creditSec), 60);
    chk("t2_shutter_n2", int'(shutterOpen), 0);
    stepCycle();
    chk("t2_shutter_n3", int'(shutterOpen), 1);
    firstLamp = -1;
    endCnt = 0;
    for (int k = 5; k <= 6400; k++) begin
      stepCycle();
      if (firstLamp < 0 && warnLamp) firstLamp = k;
      if (sessionEnd) endCnt++;
    end
    chk("t2_warn_entry_step", firstLamp, 5005);
    chk("t2_end_pulses", endCnt, 1);
    chk("t2_final_credit", int'(creditSec), 0);
    chk("t2_final_shutter", int'(shutterOpen), 0);

    // 3: wrap 250 -> 4 after priming at 250
    nRST = 1'b0;
    billAccumed = 8'd250;
    steps(2);
    nRST = 1'b1;
    steps(10);
    chk("t3_no_payout", int'(creditSec), 0);
    billAccumed = 8'd4;
    steps(3);
    chk("t3_wrap_credit", int'(creditSec), 60);

    // 4: top-up while warning with 5 s left
    waited = 0;
    while (creditSec != 12'd5 && waited < 7000) begin
      stepCycle();
      waited++;
    end
    chk("t4_reach_5", int'(creditSec), 5);
    chk("t4_lamp_in_warn", int'(shutterOpen), 1);
    bump(10);
    steps(3);
    chk("t4_topup_credit", int'(creditSec), 65);
    stepCycle();
    chk("t4_lamp_forced_off", int'(warnLamp), 0);
    chk("t4_shutter_still", int'(shutterOpen), 1);

    // 5: back-to-back increments, saturation
    bump(200); stepCycle();
    bump(200); stepCycle();
    bump(200); stepCycle();
    bump(100); stepCycle();
    steps(2);
    chk("t5_saturate", int'(creditSec), CMAX);

    // 6: asynchronous reset mid-session
    steps(7);
    @(posedge CLK_10MHZ);
    #3;
    nRST = 1'b0;
    #1;
    chk("t6_async_shutter", int'(shutterOpen), 0);
    chk("t6_async_credit", int'(creditSec), 0);
    chk("t6_async_lamp", int'(warnLamp), 0);
    chk("t6_async_end", int'(sessionEnd), 0);
    steps(3);

    // Random money arrivals: a dense burst, then sparse single units so sessions end and restart
    billAccumed = 8'($urandom_range(0, 255));
    stepCycle();
    nRST = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 249) == 0) bump(int'($urandom_range(1, 2)));
      stepCycle();
    end
    for (int i = 0; i < 11000; i++) begin
      if ($urandom_range(0, 1999) == 0) bump(1);
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
